// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared constants and sizing helper for the echo datapath
package echo_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/echo_fifo_mem.sv
// rtl/echo_fifo_mem.sv - Width x Depth register array, one write port, async read port
module echo_fifo_mem #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(Depth)-1:0] wr_addr,
  input  logic [Width-1:0]         wr_data,
  input  logic [$clog2(Depth)-1:0] rd_addr,
  output logic [Width-1:0]         rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/echo_line_fifo.sv
// rtl/echo_line_fifo.sv - first-word-fall-through echo FIFO with occupancy status
// ECHO_LINE_MODE_EN holds output until a terminator-ended line is stored.
module echo_line_fifo
  import echo_pkg::*;
#(
  parameter int               Width      = DEFAULT_WIDTH,
  parameter int               Depth      = DEFAULT_DEPTH,
  parameter logic [Width-1:0] Terminator = Width'(ASCII_CR)
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic [Width-1:0]                DataIn,
  input  logic                            DataInValid,
  output logic                            DataInReady,
  output logic [Width-1:0]                DataOut,
  output logic                            DataOutValid,
  input  logic                            DataOutReady,
  output logic [count_width(Depth)-1:0]   Count,
  output logic                            Full,
  output logic                            Empty,
  output logic [count_width(Depth)-1:0]   LinesPending
);

  localparam int AW = $clog2(Depth);
  localparam int CW = count_width(Depth);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          wr_acc;
  logic          rd_acc;

  assign Count       = count_q;
  assign Full        = (count_q == CW'(Depth));
  assign Empty       = (count_q == '0);
  assign DataInReady = !Full;
  assign wr_acc      = DataInValid && DataInReady;
  assign rd_acc      = DataOutValid && DataOutReady;

  echo_fifo_mem #(
    .Width (Width),
    .Depth (Depth)
  ) u_mem (
    .clk     (Clock),
    .wr_en   (wr_acc && !Reset),
    .wr_addr (wr_ptr),
    .wr_data (DataIn),
    .rd_addr (rd_ptr),
    .rd_data (DataOut)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ECHO_LINE_MODE_EN
  logic [CW-1:0] lines_q;
  logic          term_in;
  logic          term_out;

  assign term_in      = wr_acc && (DataIn == Terminator);
  assign term_out     = rd_acc && (DataOut == Terminator);
  assign LinesPending = lines_q;
  // Full also releases output so a line longer than the FIFO cannot deadlock.
  assign DataOutValid = !Empty && ((lines_q != '0) || Full);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lines_q <= '0;
    end else begin
      case ({term_in, term_out})
        2'b10:   lines_q <= lines_q + CW'(1);
        2'b01:   lines_q <= lines_q - CW'(1);
        default: lines_q <= lines_q;
      endcase
    end
  end
`else
  logic unused_terminator;

  assign unused_terminator = ^Terminator;
  assign LinesPending      = '0;
  assign DataOutValid      = !Empty;
`endif

endmodule

// File: tb/tb_echo_line_fifo.sv
// tb/tb_echo_line_fifo.sv - directed self-checking bench for echo_line_fifo
module tb_echo_line_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic [4:0] lines;

  int total = 0;
  int bad   = 0;

  echo_line_fifo #(
    .Width      (8),
    .Depth      (16),
    .Terminator (8'h0D)
  ) dut (
    .Clock        (clk),
    .Reset        (rst),
    .DataIn       (din),
    .DataInValid  (din_valid),
    .DataInReady  (din_ready),
    .DataOut      (dout),
    .DataOutValid (dout_valid),
    .DataOutReady (dout_ready),
    .Count        (count),
    .Full         (full),
    .Empty        (empty),
    .LinesPending (lines)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; din = 8'h00; din_valid = 1'b0; dout_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_lines", lines, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_in_ready", din_ready, 1);
    check("rst_out_valid", dout_valid, 0);

`ifndef ECHO_LINE_MODE_EN
    // three characters straight through with the consumer always ready
    dout_ready = 1'b1;
    din = 8'h41; din_valid = 1'b1; tick();
    check("abc_valid0", dout_valid, 1);
    check("abc_data0", dout, 8'h41);
    check("abc_count0", count, 1);
    din = 8'h42; tick();
    check("abc_data1", dout, 8'h42);
    check("abc_count1", count, 1);
    din = 8'h43; tick();
    check("abc_data2", dout, 8'h43);
    din_valid = 1'b0; tick();
    check("abc_count_end", count, 0);
    check("abc_empty_end", empty, 1);
    check("abc_valid_end", dout_valid, 0);
    dout_ready = 1'b0;
`endif

    // fill to depth, then try one more write
    dout_ready = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 8'h10 + 8'(i);
      tick();
    end
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_in_ready", din_ready, 0);
    check("fill_out_valid", dout_valid, 1);
    din = 8'hFF; tick();
    din_valid = 1'b0;
    check("overflow_count", count, 16);
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", dout_valid, 1);
      check("drain_data", dout, 8'h10 + 8'(i));
      tick();
`ifdef ECHO_LINE_MODE_EN
      if (i == 0) begin
        check("long_line_gated", dout_valid, 0);
        check("long_line_lines", lines, 0);
        dout_ready = 1'b0;
        din = 8'h0D; din_valid = 1'b1; tick();
        din_valid = 1'b0;
        check("long_line_term_lines", lines, 1);
        dout_ready = 1'b1;
      end
`endif
    end
`ifdef ECHO_LINE_MODE_EN
    check("long_line_term_data", dout, 8'h0D);
    tick();
    check("long_line_lines_end", lines, 0);
`endif
    check("drain_count_end", count, 0);
    check("drain_empty_end", empty, 1);
    dout_ready = 1'b0;

`ifndef ECHO_LINE_MODE_EN
    // steady-state simultaneous write/read at occupancy 5, wrapping the pointers
    din_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = 8'h20 + 8'(k);
      tick();
    end
    check("thr_pre_count", count, 5);
    dout_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = 8'h25 + 8'(k);
      check("thr_data", dout, 8'h20 + 8'(k));
      tick();
      check("thr_count", count, 5);
    end
    din_valid = 1'b0;
    for (int k = 40; k < 45; k++) begin
      check("thr_tail", dout, 8'h20 + 8'(k));
      tick();
    end
    check("thr_empty", empty, 1);
    dout_ready = 1'b0;
`else
    // a short line is held until its terminator arrives
    dout_ready = 1'b1;
    din = 8'h68; din_valid = 1'b1; tick();
    check("line_h_valid", dout_valid, 0);
    check("line_h_count", count, 1);
    din = 8'h69; tick();
    check("line_i_valid", dout_valid, 0);
    check("line_i_count", count, 2);
    din = 8'h0D; tick();
    din_valid = 1'b0;
    check("line_cr_valid", dout_valid, 1);
    check("line_cr_lines", lines, 1);
    check("line_out0", dout, 8'h68);
    tick();
    check("line_out1", dout, 8'h69);
    tick();
    check("line_out2", dout, 8'h0D);
    check("line_lines_before", lines, 1);
    tick();
    check("line_lines_after", lines, 0);
    check("line_empty", empty, 1);
    check("line_valid_end", dout_valid, 0);
    dout_ready = 1'b0;
`endif

    // reset in the middle of traffic discards everything
    din_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      din = 8'h50 + 8'(k);
      tick();
    end
    check("mid_count", count, 7);
    din = 8'hEE; dout_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_ready", din_ready, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_lines", lines, 0);
    din = 8'h0D; din_valid = 1'b1; tick();
    din_valid = 1'b0;
    check("post_rst_count", count, 1);
    check("post_rst_valid", dout_valid, 1);
    check("post_rst_data", dout, 8'h0D);
    dout_ready = 1'b1; tick();
    dout_ready = 1'b0;
    check("post_rst_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
